// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - fetch stage bus bundle: instruction memory port, redirect and decode handshake
// Ports (signals):
//   imem_req/imem_addr/imem_rdata   synchronous 1-cycle-latency instruction memory
//   redirect_valid/redirect_pc      branch redirect into fetch
//   out_valid/out_ready             decode handshake
//   out_pc/out_instr                head of the fetch queue
// master = fetch unit side, slave = memory/decode side.
interface fetch_if #(
    parameter int XLEN = 32,
    parameter int AW   = 8
);
    logic            imem_req;
    logic [AW-1:0]   imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;

    modport master (
        output imem_req, imem_addr, out_valid, out_pc, out_instr,
        input  imem_rdata, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_pc, out_instr,
        output imem_rdata, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - parametrised instruction fetch stage with show-ahead queue and redirect flush
// Ports:
//   clk    clock, all state on rising edge
//   reset  synchronous, active-low
//   bus    fetch_if.master: imem request/address/data, redirect, decode valid/ready with {pc, instr}
module fetch_unit #(
    parameter int              XLEN       = 32,
    parameter int              IMEM_DEPTH = 256,
    parameter int              FIFO_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic     clk,
    input  logic     reset,
    fetch_if.master  bus
);
    localparam int AW = $clog2(IMEM_DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            inflight_q, inflight_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [XLEN-1:0] pc_mem    [FIFO_DEPTH];
    logic [XLEN-1:0] instr_mem [FIFO_DEPTH];

    logic            issue;
    logic            push;
    logic            pop;
    logic [CW:0]     used;
    logic            unused_bits;

    // Credits count both queued entries and the outstanding memory read, so
    // a return always has a slot; a pop in the same cycle is not counted.
    assign used  = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    assign issue = reset && !bus.redirect_valid && (used < (CW+1)'(FIFO_DEPTH));
    assign push  = reset && inflight_q && !bus.redirect_valid;
    assign pop   = bus.out_valid && bus.out_ready;

    assign bus.imem_req  = issue;
    assign bus.imem_addr = fetch_pc_q[AW+1:2];
    assign bus.out_valid = reset && (count_q != '0);
    assign bus.out_pc    = pc_mem[head_q];
    assign bus.out_instr = instr_mem[head_q];

    // Redirect targets are forced word aligned.
    assign unused_bits = ^bus.redirect_pc[1:0];

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = issue;
        count_d    = count_q;
        head_d     = head_q;
        tail_d     = tail_q;
        if (bus.redirect_valid) begin
            // Redirect wins over any simultaneous push or pop.
            fetch_pc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
            inflight_d = 1'b0;
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
        end else begin
            if (issue) begin
                req_pc_d   = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (push) begin
                tail_d = tail_q + PW'(1);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    // Queue storage carries no reset; count gates its visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail_q]    <= req_pc_q;
            instr_mem[tail_q] <= bus.imem_rdata;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;
    logic clk = 1'b0;
    logic reset;
    logic reset2;
    int   total = 0;
    int   bad   = 0;

    logic [63:0] exp_q  [$];
    logic [63:0] exp2_q [$];

    fetch_if #(.XLEN(32), .AW(8)) bus  ();
    fetch_if #(.XLEN(32), .AW(8)) bus2 ();

    fetch_unit #(.XLEN(32), .IMEM_DEPTH(256), .FIFO_DEPTH(4), .RESET_PC(32'h0)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    fetch_unit #(.XLEN(32), .IMEM_DEPTH(256), .FIFO_DEPTH(4), .RESET_PC(32'h3F8)) u_dut2 (
        .clk   (clk),
        .reset (reset2),
        .bus   (bus2.master)
    );

    always #5 clk = ~clk;

    // Instruction memory model: rdata = 0xA0000000 | word address, one cycle after the request.
    always @(posedge clk) begin
        if (bus.imem_req)  bus.imem_rdata  <= 32'hA000_0000 | 32'(bus.imem_addr);
        if (bus2.imem_req) bus2.imem_rdata <= 32'hA000_0000 | 32'(bus2.imem_addr);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitors: a handshake cancelled by redirect or reset is not a transfer.
    always @(negedge clk) begin
        if (reset === 1'b1 && bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL mon_unexpected: got %h want none", {bus.out_pc, bus.out_instr});
            end else begin
                check("mon_pc_instr", {bus.out_pc, bus.out_instr}, exp_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (reset2 === 1'b1 && bus2.out_valid && bus2.out_ready && !bus2.redirect_valid) begin
            if (exp2_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL mon2_unexpected: got %h want none", {bus2.out_pc, bus2.out_instr});
            end else begin
                check("mon2_pc_instr", {bus2.out_pc, bus2.out_instr}, exp2_q.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic expect_pc(input logic [31:0] pc);
        exp_q.push_back({pc, 32'hA000_0000 | ((pc >> 2) & 32'hFF)});
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && exp_q.size() != 0; n++) cyc();
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    logic [7:0] addr2_exp [4];

    initial begin
        addr2_exp = '{8'd254, 8'd255, 8'd0, 8'd1};
        reset = 1'b0; reset2 = 1'b0;
        bus.out_ready = 1'b0;  bus.redirect_valid = 1'b0;  bus.redirect_pc = '0;
        bus2.out_ready = 1'b0; bus2.redirect_valid = 1'b0; bus2.redirect_pc = '0;
        repeat (3) cyc();
        smp();
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_req", 64'(bus.imem_req), 64'd0);

        // 1: release reset, stream eight instructions.
        cyc();
        reset = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) expect_pc(32'(i * 4));
        for (int c = 0; c < 10; c++) begin
            smp();
            if (c == 0) begin
                check("s1_req_c0", 64'(bus.imem_req), 64'd1);
                check("s1_addr_c0", 64'(bus.imem_addr), 64'd0);
            end
            check("s1_valid_cycle", 64'(bus.out_valid), (c >= 2) ? 64'd1 : 64'd0);
            cyc();
        end
        bus.out_ready = 1'b0;
        check("s1_drained", 64'(exp_q.size()), 64'd0);

        // 2: stall fills the queue, then resume in order.
        repeat (10) cyc();
        smp();
        check("s2_req_full", 64'(bus.imem_req), 64'd0);
        check("s2_valid_full", 64'(bus.out_valid), 64'd1);
        check("s2_head_pc", 64'(bus.out_pc), 64'h20);
        cyc();
        for (int i = 0; i < 6; i++) expect_pc(32'h20 + 32'(i * 4));
        bus.out_ready = 1'b1;
        drain();
        bus.out_ready = 1'b0;

        // 3: three queued plus one in flight, redirect to 0x40.
        repeat (10) cyc();
        expect_pc(32'h38);
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
        cyc();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h40;
        smp();
        check("s3_req_k", 64'(bus.imem_req), 64'd0);
        cyc();
        bus.redirect_valid = 1'b0;
        bus.out_ready = 1'b1;
        expect_pc(32'h40);
        expect_pc(32'h44);
        smp();
        check("s3_valid_k1", 64'(bus.out_valid), 64'd0);
        check("s3_req_k1", 64'(bus.imem_req), 64'd1);
        check("s3_addr_k1", 64'(bus.imem_addr), 64'h10);
        cyc(); smp();
        check("s3_valid_k2", 64'(bus.out_valid), 64'd0);
        cyc(); smp();
        check("s3_valid_k3", 64'(bus.out_valid), 64'd1);
        check("s3_pc_k3", 64'(bus.out_pc), 64'h40);
        check("s3_instr_k3", 64'(bus.out_instr), 64'hA000_0010);

        // 4: misaligned redirect coinciding with a pop.
        cyc();
        cyc();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h43;
        smp();
        check("s4_pop_k", 64'(bus.out_valid && bus.out_ready), 64'd1);
        check("s4_head_k", 64'(bus.out_pc), 64'h48);
        cyc();
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) expect_pc(32'h40 + 32'(i * 4));
        smp();
        check("s4_valid_k1", 64'(bus.out_valid), 64'd0);
        cyc(); smp();
        check("s4_valid_k2", 64'(bus.out_valid), 64'd0);
        cyc(); smp();
        check("s4_pc_k3", 64'(bus.out_pc), 64'h40);
        drain();
        bus.out_ready = 1'b0;

        // 6: one reset cycle with a full queue.
        repeat (10) cyc();
        smp();
        check("s6_full_valid", 64'(bus.out_valid), 64'd1);
        cyc();
        reset = 1'b0;
        smp();
        check("s6_rst_valid", 64'(bus.out_valid), 64'd0);
        check("s6_rst_req", 64'(bus.imem_req), 64'd0);
        cyc();
        reset = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) expect_pc(32'(i * 4));
        smp();
        check("s6_valid_c0", 64'(bus.out_valid), 64'd0);
        check("s6_addr_c0", 64'(bus.imem_addr), 64'd0);
        cyc(); smp();
        check("s6_valid_c1", 64'(bus.out_valid), 64'd0);
        cyc(); smp();
        check("s6_valid_c2", 64'(bus.out_valid), 64'd1);
        drain();
        bus.out_ready = 1'b0;

        // 5: RESET_PC = 0x3F8, memory address wraps but PC does not.
        cyc();
        reset2 = 1'b1;
        bus2.out_ready = 1'b1;
        exp2_q.push_back({32'h3F8, 32'hA000_00FE});
        exp2_q.push_back({32'h3FC, 32'hA000_00FF});
        exp2_q.push_back({32'h400, 32'hA000_0000});
        exp2_q.push_back({32'h404, 32'hA000_0001});
        for (int c = 0; c < 4; c++) begin
            smp();
            check("s5_addr", 64'(bus2.imem_addr), 64'(addr2_exp[c]));
            cyc();
        end
        for (int n = 0; n < 100 && exp2_q.size() != 0; n++) cyc();
        check("s5_drain", 64'(exp2_q.size()), 64'd0);
        bus2.out_ready = 1'b0;

        repeat (3) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
